// File: rtl/avst_keccak_sink_if.sv
// Avalon-ST sink bus carried into avst_keccak_sink.
// Signals keep the original port names so existing hookups map one-to-one.
//   asink_data   : beat data, lane [31:24] is the first message byte
//   asink_valid  : beat valid
//   asink_ready  : beat accept (driven by the sink)
//   asink_sop    : first beat of the packet
//   asink_eop    : last beat of the packet
//   asink_empty  : invalid low-order lanes on the eop beat
// master = packet source, slave = avst_keccak_sink.
interface avst_keccak_sink_if #(
  parameter int unsigned EMPTY_W = 2
);
  logic [31:0]        asink_data;
  logic               asink_valid;
  logic               asink_ready;
  logic               asink_sop;
  logic               asink_eop;
  logic [EMPTY_W-1:0] asink_empty;

  modport master (
    output asink_data,
    output asink_valid,
    input  asink_ready,
    output asink_sop,
    output asink_eop,
    output asink_empty
  );

  modport slave (
    input  asink_data,
    input  asink_valid,
    output asink_ready,
    input  asink_sop,
    input  asink_eop,
    input  asink_empty
  );
endinterface

// File: rtl/avst_keccak_sink.sv
// Ingress stage for the keccak hash core: takes one message as an Avalon-ST
// packet of 32-bit beats and serialises it, most significant lane first, onto
// the core's byte interface while honouring buffer_full. After the final byte
// it refuses further data until reset (the core hashes one message per reset).
//
// Ports:
//   clk, reset     : clock, synchronous active-high reset
//   sink           : Avalon-ST sink bus (avst_keccak_sink_if.slave)
//   k_in           : byte to the core
//   k_in_ready     : byte valid to the core
//   k_is_last      : current byte is the final message byte
//   k_buffer_full  : core cannot take a byte this cycle
//   busy           : packet in progress (sop accepted, last byte not yet sent)
//   done           : final byte delivered
//   err_proto      : sticky protocol-error flag
module avst_keccak_sink #(
  parameter int unsigned SYMBOLS = 4,  // only 4 is supported
  parameter int unsigned EMPTY_W = 2
) (
  input  logic                     clk,
  input  logic                     reset,
  avst_keccak_sink_if.slave        sink,
  output logic [7:0]               k_in,
  output logic                     k_in_ready,
  output logic                     k_is_last,
  input  logic                     k_buffer_full,
  output logic                     busy,
  output logic                     done,
  output logic                     err_proto
);

  localparam int unsigned DATA_W = 8 * SYMBOLS;

  typedef enum logic [1:0] {
    S_IDLE,
    S_EMIT,
    S_NEXT,
    S_DONE
  } state_t;

  state_t              state_q, state_d;
  logic [DATA_W-1:0]   hold_q, hold_d;
  logic [1:0]          idx_q, idx_d;
  logic [2:0]          nbytes_q, nbytes_d;
  logic                last_beat_q, last_beat_d;
  logic                err_q, err_d;

  logic [DATA_W-1:0]   data_s;
  logic [EMPTY_W-1:0]  empty_s;
  logic                ready_s;
  logic                xfer_s;
  logic                final_byte_s;
  logic [2:0]          beat_nbytes_s;

  assign data_s  = sink.asink_data;
  assign empty_s = sink.asink_empty;

  // Valid byte count of an incoming beat; empty only matters on eop.
  assign beat_nbytes_s = sink.asink_eop ? (3'd4 - 3'(empty_s)) : 3'd4;

  assign final_byte_s = ({1'b0, idx_q} == (nbytes_q - 3'd1));

  always_comb begin
    k_in = '0;
    case (idx_q)
      2'd0: k_in = hold_q[31:24];
      2'd1: k_in = hold_q[23:16];
      2'd2: k_in = hold_q[15:8];
      default: k_in = hold_q[7:0];
    endcase
  end

  always_comb begin
    state_d     = state_q;
    hold_d      = hold_q;
    idx_d       = idx_q;
    nbytes_d    = nbytes_q;
    last_beat_d = last_beat_q;
    err_d       = err_q;
    ready_s     = 1'b0;
    xfer_s      = 1'b0;
    k_is_last   = 1'b0;
    done        = 1'b0;

    case (state_q)
      S_IDLE: begin
        ready_s = 1'b1;
        if (sink.asink_valid) begin
          if (sink.asink_sop) begin
            hold_d      = data_s;
            nbytes_d    = beat_nbytes_s;
            last_beat_d = sink.asink_eop;
            idx_d       = '0;
            state_d     = S_EMIT;
          end else begin
            // Beat without a preceding sop: consumed and discarded.
            err_d = 1'b1;
          end
        end
      end

      S_EMIT: begin
        xfer_s    = !k_buffer_full && !reset;
        k_is_last = xfer_s && last_beat_q && final_byte_s;
        if (xfer_s) begin
          if (final_byte_s) begin
            state_d = last_beat_q ? S_DONE : S_NEXT;
          end else begin
            idx_d = idx_q + 2'd1;
          end
        end
      end

      S_NEXT: begin
        ready_s = 1'b1;
        if (sink.asink_valid) begin
          // A repeated sop mid-packet is flagged but still treated as data.
          if (sink.asink_sop) begin
            err_d = 1'b1;
          end
          hold_d      = data_s;
          nbytes_d    = beat_nbytes_s;
          last_beat_d = sink.asink_eop;
          idx_d       = '0;
          state_d     = S_EMIT;
        end
      end

      default: begin
        done = 1'b1;
      end
    endcase
  end

  // Ready comes from registered state only; masked during reset so no beat
  // is ever handshaken in a cycle whose state update is discarded.
  assign sink.asink_ready = ready_s && !reset;
  assign k_in_ready       = xfer_s;
  assign busy             = (state_q == S_EMIT) || (state_q == S_NEXT);
  assign err_proto        = err_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      hold_q      <= '0;
      idx_q       <= '0;
      nbytes_q    <= '0;
      last_beat_q <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      hold_q      <= hold_d;
      idx_q       <= idx_d;
      nbytes_q    <= nbytes_d;
      last_beat_q <= last_beat_d;
      err_q       <= err_d;
    end
  end

endmodule

// File: tb/tb_avst_keccak_sink.sv
module tb_avst_keccak_sink;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] k_in;
  logic       k_in_ready;
  logic       k_is_last;
  logic       kbf;
  logic       kbf_force;
  logic       kbf_rnd;
  bit         rnd_en;
  logic       busy;
  logic       done;
  logic       err_proto;

  always #5 clk = ~clk;

  avst_keccak_sink_if #(.EMPTY_W(2)) sif ();

  avst_keccak_sink #(
    .SYMBOLS(4),
    .EMPTY_W(2)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .sink          (sif.slave),
    .k_in          (k_in),
    .k_in_ready    (k_in_ready),
    .k_is_last     (k_is_last),
    .k_buffer_full (kbf),
    .busy          (busy),
    .done          (done),
    .err_proto     (err_proto)
  );

  assign kbf = rnd_en ? kbf_rnd : kbf_force;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard entry: {is_last, byte}
  logic [8:0] sb[$];
  int         xfer_cnt = 0;
  int         last_xfer_cyc = 0;
  int         xfer_cyc[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Byte monitor: a transfer is any cycle with k_in_ready=1.
  always @(negedge clk) begin
    if (reset === 1'b0) begin
      if (k_is_last && !k_in_ready) check("last_without_ready", k_is_last, 0);
      if (k_in_ready) begin
        if (sb.size() == 0) begin
          check("spurious_byte", k_in_ready, 0);
        end else begin
          logic [8:0] e;
          e = sb.pop_front();
          check("k_in", k_in, e[7:0]);
          check("k_is_last", k_is_last, e[8]);
        end
        xfer_cnt++;
        last_xfer_cyc = cyc;
        xfer_cyc.push_back(cyc);
      end
    end
  end

  initial begin
    kbf_rnd = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      kbf_rnd = ($urandom_range(0, 3) == 0);
    end
  end

  // Called just after a negedge; applies reset for one edge and checks values.
  task automatic do_reset();
    reset = 1'b1;
    sif.asink_valid = 1'b0;
    @(negedge clk);
    check("rst_asink_ready", sif.asink_ready, 0);
    check("rst_k_in_ready", k_in_ready, 0);
    check("rst_k_is_last", k_is_last, 0);
    check("rst_k_in", k_in, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_err", err_proto, 0);
    #1;
    sb.delete();
    xfer_cyc.delete();
    xfer_cnt = 0;
    reset = 1'b0;
    @(negedge clk);
    check("post_rst_asink_ready", sif.asink_ready, 1);
    check("post_rst_k_in_ready", k_in_ready, 0);
    #1;
  endtask

  task automatic send_beat(input logic [31:0] d, input bit sop, input bit eop,
                           input logic [1:0] empty, input bit push, output int acc_cyc);
    bit acc;
    int n;
    acc = 0;
    acc_cyc = -1;
    sif.asink_data  = d;
    sif.asink_sop   = sop;
    sif.asink_eop   = eop;
    sif.asink_empty = empty;
    sif.asink_valid = 1'b1;
    for (int i = 0; i < 200; i++) begin
      if (sif.asink_ready) begin
        acc_cyc = cyc;
        @(posedge clk);
        acc = 1;
        break;
      end
      @(negedge clk);
      #1;
    end
    if (acc && push) begin
      n = eop ? (4 - int'(empty)) : 4;
      for (int k = 0; k < n; k++)
        sb.push_back({(eop && (k == n - 1)), d[31 - 8*k -: 8]});
    end
    check("beat_accepted", 32'(acc), 1);
    @(negedge clk);
    #1;
    sif.asink_valid = 1'b0;
  endtask

  task automatic wait_xfers(input int target);
    for (int i = 0; i < 500; i++) begin
      if (xfer_cnt >= target) break;
      @(negedge clk);
      #1;
    end
    check("xfer_reached", 32'(xfer_cnt >= target), 1);
  endtask

  task automatic wait_done(input int exp_bytes);
    for (int i = 0; i < 500; i++) begin
      if (done) break;
      @(negedge clk);
      #1;
    end
    check("done", done, 1);
    check("done_cycle", cyc, last_xfer_cyc + 1);
    check("done_asink_ready", sif.asink_ready, 0);
    check("done_k_in_ready", k_in_ready, 0);
    check("done_busy", busy, 0);
    check("xfer_total", xfer_cnt, exp_bytes);
    check("sb_empty", sb.size(), 0);
  endtask

  initial begin
    int a0;
    int a1;
    #200_000;
    $display("FAIL watchdog: simulation did not complete (checks=%0d)", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    int acc;
    int dummy;
    logic [31:0] w;
    reset = 1'b1;
    kbf_force = 1'b0;
    rnd_en = 0;
    sif.asink_valid = 1'b0;
    sif.asink_data  = '0;
    sif.asink_sop   = 1'b0;
    sif.asink_eop   = 1'b0;
    sif.asink_empty = '0;
    repeat (2) @(negedge clk);
    #1;

    // Single-beat "abc"
    do_reset();
    send_beat(32'h61626300, 1, 1, 2'd1, 1, acc);
    check("abc_busy", busy, 1);
    wait_xfers(1);
    check("abc_first_latency", xfer_cyc[0], acc + 1);
    wait_done(3);
    check("abc_consecutive", xfer_cyc[2] - xfer_cyc[0], 2);
    repeat (3) @(negedge clk);
    #1;
    check("abc_ready_stays_0", sif.asink_ready, 0);
    check("abc_done_stays_1", done, 1);

    // Two beats, one reload cycle between them
    do_reset();
    send_beat(32'h00010203, 1, 0, 2'd0, 1, acc);
    send_beat(32'h04050607, 0, 1, 2'd0, 1, dummy);
    wait_done(8);
    check("two_first4", xfer_cyc[3] - xfer_cyc[0], 3);
    check("two_reload_gap", xfer_cyc[4] - xfer_cyc[3], 2);
    check("two_err", err_proto, 0);

    // Backpressure after byte 0x62
    do_reset();
    send_beat(32'h61626300, 1, 1, 2'd1, 1, acc);
    wait_xfers(2);
    @(posedge clk);
    #1;
    kbf_force = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("bp_k_in_ready", k_in_ready, 0);
      check("bp_k_in_hold", k_in, 8'h63);
    end
    @(posedge clk);
    #1;
    kbf_force = 1'b0;
    wait_done(3);
    check("bp_resume", xfer_cyc[2] - xfer_cyc[1], 11);

    // sop=0 in IDLE is dropped and flagged
    do_reset();
    send_beat(32'hDEADBEEF, 0, 1, 2'd0, 0, acc);
    check("drop_err", err_proto, 1);
    check("drop_busy", busy, 0);
    check("drop_ready", sif.asink_ready, 1);
    repeat (4) @(negedge clk);
    #1;
    check("drop_no_bytes", xfer_cnt, 0);
    send_beat(32'hA1B2C3D4, 1, 1, 2'd0, 1, acc);
    wait_done(4);
    check("drop_err_sticky", err_proto, 1);

    // Reset after 2 bytes of a 3-beat packet
    do_reset();
    send_beat(32'h10203040, 1, 0, 2'd0, 1, acc);
    wait_xfers(2);
    do_reset();
    send_beat(32'h11223344, 1, 1, 2'd2, 1, acc);
    wait_done(2);

    // 136-byte message with random backpressure
    do_reset();
    rnd_en = 1;
    for (int b = 0; b < 34; b++) begin
      for (int k = 0; k < 4; k++) w[31 - 8*k -: 8] = 8'((b*4 + k) * 7 + 3);
      send_beat(w, (b == 0), (b == 33), 2'd0, 1, acc);
    end
    wait_done(136);
    rnd_en = 0;
    check("long_err", err_proto, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
